// File: rtl/inst_fetch_mod.sv
// inst_fetch_mod
//   Instruction fetch front end for the control unit. Reads opcode bytes from
//   the memory bus at the current PC and requests one PC increment for each
//   byte it consumes. It presents a 9-bit opcode index {cb, byte} and holds it
//   stable until the control unit reports that the instruction has completed.
//
//   Build option:
//     INST_FETCH_CB_PREFIX_EN  defined     : a CB_OPCODE byte starts a second
//                                            fetch, and inst_cb marks the result.
//                              not defined : CB_OPCODE is latched like any other
//                                            opcode; inst_cb is tied to 0.
//
//   Ports:
//     clock, reset  rising-edge clock; synchronous active-high reset
//     pc_in         current PC from the register file
//     mem_addr      read address (pc_in while mem_rd=1, otherwise 0)
//     mem_rd        read request to the memory bus
//     mem_rdata     read data, valid when mem_ready=1
//     mem_ready     the bus completes the read this cycle
//     pc_inc        one-cycle pulse; the register file increments the PC
//     inst_done     the control unit has finished the current instruction
//     inst_buffer   latched opcode byte (the second byte when CB-prefixed)
//     inst_cb       the current opcode is CB-prefixed
//     opcode_index  {inst_cb, inst_buffer}
//     inst_valid    inst_buffer and inst_cb are stable and valid

module inst_fetch_mod #(
    parameter logic [7:0]  CB_OPCODE  = 8'hCB,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ready,
    output logic                  pc_inc,
    input  logic                  inst_done,
    output logic [7:0]            inst_buffer,
    output logic                  inst_cb,
    output logic [8:0]            opcode_index,
    output logic                  inst_valid
);

`ifdef INST_FETCH_CB_PREFIX_EN
    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        CB_FETCH = 2'd1,
        HOLD     = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd2
    } state_t;
`endif

    state_t state;
    state_t state_next;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: begin
`ifdef INST_FETCH_CB_PREFIX_EN
                if (mem_ready) begin
                    state_next = (mem_rdata == CB_OPCODE) ? CB_FETCH : HOLD;
                end
`else
                if (mem_ready) begin
                    state_next = HOLD;
                end
`endif
            end
`ifdef INST_FETCH_CB_PREFIX_EN
            CB_FETCH: begin
                if (mem_ready) begin
                    state_next = HOLD;
                end
            end
`endif
            HOLD: begin
                if (inst_done) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Bus-side outputs. Reset masks pc_inc so that an abandoned read never
    // advances the PC.
    always_comb begin
        mem_rd = 1'b0;
        unique case (state)
            FETCH:    mem_rd = 1'b1;
`ifdef INST_FETCH_CB_PREFIX_EN
            CB_FETCH: mem_rd = 1'b1;
`endif
            default:  mem_rd = 1'b0;
        endcase
        pc_inc   = mem_rd & mem_ready & ~reset;
        mem_addr = mem_rd ? pc_in : '0;
    end

    // Opcode capture. inst_valid is set on the same edge that enters HOLD, so
    // it is high for exactly the cycles spent in HOLD.
`ifdef INST_FETCH_CB_PREFIX_EN
    logic cb_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            inst_buffer <= '0;
            cb_q        <= 1'b0;
            inst_valid  <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (mem_ready) begin
                        if (mem_rdata == CB_OPCODE) begin
                            cb_q <= 1'b1;
                        end else begin
                            inst_buffer <= mem_rdata;
                            cb_q        <= 1'b0;
                            inst_valid  <= 1'b1;
                        end
                    end
                end
                // The second byte is taken verbatim, even when it is CB_OPCODE.
                CB_FETCH: begin
                    if (mem_ready) begin
                        inst_buffer <= mem_rdata;
                        inst_valid  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (inst_done) begin
                        inst_valid <= 1'b0;
                    end
                end
                default: inst_valid <= 1'b0;
            endcase
        end
    end

    assign inst_cb = cb_q;
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            inst_buffer <= '0;
            inst_valid  <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (mem_ready) begin
                        inst_buffer <= mem_rdata;
                        inst_valid  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (inst_done) begin
                        inst_valid <= 1'b0;
                    end
                end
                default: inst_valid <= 1'b0;
            endcase
        end
    end

    assign inst_cb = 1'b0;
`endif

    assign opcode_index = {inst_cb, inst_buffer};

endmodule

// File: tb/tb_inst_fetch_mod.sv
// tb_inst_fetch_mod
//   Self-checking bench for inst_fetch_mod. The bench acts as the register file
//   (it holds the PC and increments it on pc_inc) and as a 64 KiB byte memory.
//   The reference model works at the instruction level. It decides how many
//   bytes an instruction consumes and which opcode index results, then derives
//   the cycle-by-cycle bus behaviour from the byte count, the wait states
//   chosen, and the number of hold cycles.
//   The CB-prefix expectations follow INST_FETCH_CB_PREFIX_EN, as in the design.

module tb_inst_fetch_mod;

`ifdef INST_FETCH_CB_PREFIX_EN
    localparam bit CB_EN = 1'b1;
`else
    localparam bit CB_EN = 1'b0;
`endif
    localparam logic [7:0] CB_BYTE = 8'hCB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc_reg = '0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready = 1'b0;
    logic        pc_inc;
    logic        inst_done = 1'b0;
    logic [7:0]  inst_buffer;
    logic        inst_cb;
    logic [8:0]  opcode_index;
    logic        inst_valid;

    logic        pc_set = 1'b0;
    logic [15:0] pc_set_val = '0;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_pc;

    int unsigned errors = 0;
    int unsigned checks = 0;

    inst_fetch_mod #(
        .CB_OPCODE (8'hCB),
        .ADDR_WIDTH(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc_in       (pc_reg),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .pc_inc      (pc_inc),
        .inst_done   (inst_done),
        .inst_buffer (inst_buffer),
        .inst_cb     (inst_cb),
        .opcode_index(opcode_index),
        .inst_valid  (inst_valid)
    );

    always #5 clock = ~clock;

    // Register-file stand-in
    always_ff @(posedge clock) begin
        if (pc_set) pc_reg <= pc_set_val;
        else if (pc_inc) pc_reg <= pc_reg + 16'd1;
    end

    assign mem_rdata = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Holds reset for two edges and loads the PC. The second cycle checks the
    // reset values of the registered outputs.
    task automatic reset_to(input logic [15:0] pc);
        @(negedge clock);
        reset = 1'b1; pc_set = 1'b1; pc_set_val = pc;
        mem_ready = 1'b1; inst_done = 1'($urandom_range(0, 1));
        #1 check("rst_pc_inc0", pc_inc, 0);
        @(negedge clock);
        pc_set = 1'b0; mem_ready = 1'b1;
        #1;
        check("rst_pc_inc1", pc_inc, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_index", opcode_index, 0);
        check("rst_cb", inst_cb, 0);
        check("rst_mem_rd", mem_rd, 1);
        reset = 1'b0; mem_ready = 1'b0; inst_done = 1'b0;
        exp_pc = pc;
    endtask

    // Fetches one instruction at exp_pc: byte k waits w[k] cycles before ready.
    // The instruction is then held for `hold` cycles. inst_done is pulsed in the
    // last hold cycle only when `finish` is set.
    task automatic run_inst(input int unsigned w0, input int unsigned w1,
                            input int unsigned hold, input bit finish);
        logic [15:0] a0, a1;
        logic [7:0]  b0, b1;
        int unsigned nbytes;
        int unsigned w;
        logic [8:0]  exp_idx;
        a0 = exp_pc; a1 = exp_pc + 16'd1;
        b0 = mem[a0]; b1 = mem[a1];
        nbytes = (CB_EN && b0 == CB_BYTE) ? 2 : 1;
        exp_idx = (nbytes == 2) ? {1'b1, b1} : {1'b0, b0};
        for (int unsigned k = 0; k < nbytes; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int unsigned c = 0; c <= w; c++) begin
                @(negedge clock);
                mem_ready = (c == w);
                inst_done = 1'($urandom_range(0, 1));
                #1;
                check("f_mem_rd", mem_rd, 1);
                check("f_mem_addr", mem_addr, (k == 0) ? a0 : a1);
                check("f_pc_inc", pc_inc, (c == w) ? 1 : 0);
                check("f_valid", inst_valid, 0);
            end
        end
        for (int unsigned h = 0; h < hold; h++) begin
            @(negedge clock);
            mem_ready = 1'($urandom_range(0, 1));
            inst_done = finish && (h == hold - 1);
            #1;
            check("h_mem_rd", mem_rd, 0);
            check("h_mem_addr", mem_addr, 0);
            check("h_pc_inc", pc_inc, 0);
            check("h_valid", inst_valid, 1);
            check("h_index", opcode_index, exp_idx);
            check("h_cb", inst_cb, exp_idx[8]);
            check("h_buffer", inst_buffer, exp_idx[7:0]);
        end
        exp_pc = exp_pc + 16'(nbytes);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Zero-wait fetch of 0x3E; done; then 0x06 with an immediate re-fetch
        mem[16'h0100] = 8'h3E;
        mem[16'h0101] = 8'h06;
        reset_to(16'h0100);
        run_inst(0, 0, 3, 1);
        run_inst(0, 0, 2, 1);

        // CB-prefixed pair (or a plain 0xCB opcode without the prefix option)
        mem[16'h0200] = 8'hCB;
        mem[16'h0201] = 8'h7C;
        reset_to(16'h0200);
        run_inst(0, 0, 2, 1);
        check("cb_pc_after", pc_reg, CB_EN ? 16'h0202 : 16'h0201);

        // CB followed by CB: the second byte is not a new prefix
        mem[16'h0210] = 8'hCB;
        mem[16'h0211] = 8'hCB;
        reset_to(16'h0210);
        run_inst(1, 2, 1, 1);

        // Three wait states on 0x00
        mem[16'h0400] = 8'h00;
        reset_to(16'h0400);
        run_inst(3, 0, 2, 1);

        // Reset while the second byte is pending (or mid-wait without the option)
        mem[16'h0300] = 8'hCB;
        reset_to(16'h0300);
        @(negedge clock);
        mem_ready = CB_EN; inst_done = 1'b1;
        #1 check("rcb_pc_inc_a", pc_inc, CB_EN ? 1 : 0);
        @(negedge clock);
        reset = 1'b1; mem_ready = 1'b1; inst_done = 1'b0;
        #1;
        check("rcb_pc_inc_rst", pc_inc, 0);
        check("rcb_mem_rd", mem_rd, 1);
        @(negedge clock);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        check("rcb_cb", inst_cb, 0);
        check("rcb_valid", inst_valid, 0);
        check("rcb_mem_rd2", mem_rd, 1);
        check("rcb_addr", mem_addr, CB_EN ? 16'h0301 : 16'h0300);
        exp_pc = CB_EN ? 16'h0301 : 16'h0300;
        run_inst(0, 1, 2, 1);

        // Reset while holding an instruction
        run_inst(1, 0, 2, 0);
        @(negedge clock);
        reset = 1'b1; inst_done = 1'b0; mem_ready = 1'b1;
        #1;
        check("rh_valid_before", inst_valid, 1);
        check("rh_pc_inc", pc_inc, 0);
        @(negedge clock);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        check("rh_valid_after", inst_valid, 0);
        check("rh_mem_rd", mem_rd, 1);
        check("rh_addr", mem_addr, exp_pc);
        run_inst(0, 0, 1, 1);

        // Randomized instruction stream
        reset_to(16'($urandom));
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) mem[exp_pc] = CB_BYTE;
            run_inst(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                     ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                     $urandom_range(1, 3), 1'b1);
        end
        check("rand_pc_final", pc_reg, exp_pc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
